// File: rtl/modn_pkg.sv
// Shared definitions for the mod-N sequence checker family.
// Holds the checker state encoding and default counter geometry.
package modn_pkg;

    localparam int DEF_MOD = 5;
    localparam int DEF_W   = 3;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/modn_next.sv
// Combinational mod-N successor, up or down.
// Wraps by compare, so it never relies on 2^W overflow.
module modn_next
    import modn_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int W   = DEF_W
) (
    input  logic [W-1:0] x,
    input  logic         dir,
    output logic [W-1:0] next
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    always_comb begin
        if (!dir) begin
            next = (x == TOP) ? '0 : x + W'(1);
        end else begin
            next = (x == '0) ? TOP : x - W'(1);
        end
    end

endmodule

// File: rtl/modn_seq_checker.sv
// Locks onto a mod-N up/down counter stream and flywheels the
// predicted value, flagging and counting sequence errors.
module modn_seq_checker
    import modn_pkg::*;
#(
    parameter int MOD         = DEF_MOD,
    parameter int W           = DEF_W,
    parameter int ERR_W       = 8,
    parameter int LOCK_CNT    = 2,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     count_in,
    input  logic             dir,
    input  logic             clr_err,
    output logic             lock,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [W-1:0]     expected
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [W-1:0] TOP = W'(MOD - 1);

    state_t           state, state_n;
    logic [RW-1:0]    run, run_n;
    logic [BW-1:0]    bad_run, bad_n;
    logic [W-1:0]     exp_q, exp_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic             errp_q, errp_n;
    logic             wrapp_q, wrapp_n;
    logic             err_inc;

    logic [W-1:0] succ_in, succ_exp, term;
    logic         in_range, match;

    modn_next #(.MOD(MOD), .W(W)) u_next_in (
        .x    (count_in),
        .dir  (dir),
        .next (succ_in)
    );

    modn_next #(.MOD(MOD), .W(W)) u_next_exp (
        .x    (exp_q),
        .dir  (dir),
        .next (succ_exp)
    );

    assign in_range = (32'(count_in) < MOD);
    assign match    = (count_in == exp_q);
    assign term     = dir ? '0 : TOP;

    always_comb begin
        state_n = state;
        run_n   = run;
        bad_n   = bad_run;
        exp_n   = exp_q;
        errp_n  = 1'b0;
        wrapp_n = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (in_range) begin
                        exp_n   = succ_in;
                        run_n   = '0;
                        state_n = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (match) begin
                        run_n = run + RW'(1);
                        exp_n = succ_in;
                        if (run_n == RW'(LOCK_CNT)) begin
                            state_n = ST_LOCKED;
                            bad_n   = '0;
                        end
                    end else if (in_range) begin
                        exp_n = succ_in;
                        run_n = '0;
                    end else begin
                        state_n = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        bad_n   = '0;
                        exp_n   = succ_in;
                        wrapp_n = (count_in == term);
                    end else begin
                        // Flywheel: the bad sample never steers the prediction.
                        errp_n  = 1'b1;
                        err_inc = 1'b1;
                        bad_n   = bad_run + BW'(1);
                        exp_n   = succ_exp;
                        if (bad_n == BW'(UNLOCK_ERRS)) begin
                            state_n = ST_HUNT;
                        end
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        err_n = err_q;
        if (clr_err) begin
            err_n = err_inc ? ERR_W'(1) : '0;
        end else if (err_inc && (err_q != '1)) begin
            err_n = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_HUNT;
            run     <= '0;
            bad_run <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            errp_q  <= 1'b0;
            wrapp_q <= 1'b0;
        end else begin
            state   <= state_n;
            run     <= run_n;
            bad_run <= bad_n;
            exp_q   <= exp_n;
            err_q   <= err_n;
            errp_q  <= errp_n;
            wrapp_q <= wrapp_n;
        end
    end

    assign lock       = (state == ST_LOCKED);
    assign err_pulse  = errp_q;
    assign wrap_pulse = wrapp_q;
    assign err_count  = err_q;
    assign expected   = exp_q;

endmodule

// File: tb/tb_modn_seq_checker.sv
// Randomized and directed bench for modn_seq_checker (MOD=5).
// Reference model tracks modes and mod arithmetic directly.
module tb_modn_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] count_in;
    logic       dir;
    logic       clr_err;
    logic       lock;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [2:0] expected;

    int total = 0;
    int bad = 0;

    // reference model state
    localparam int HUNTING = 0, SEEDED = 1, TRACKING = 2;
    int m_mode, m_exp, m_run, m_bad, m_err;
    bit m_errp, m_wrap;

    modn_seq_checker #(
        .MOD(5), .W(3), .ERR_W(8), .LOCK_CNT(2), .UNLOCK_ERRS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .count_in   (count_in),
        .dir        (dir),
        .clr_err    (clr_err),
        .lock       (lock),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .expected   (expected)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int x, input bit d);
        return d ? (x + 4) % 5 : (x + 1) % 5;
    endfunction

    task automatic model(input bit v, input int c, input bit d,
                         input bit cl, input bit r);
        bit e;
        if (!r) begin
            m_mode = HUNTING; m_exp = 0; m_run = 0; m_bad = 0;
            m_err = 0; m_errp = 0; m_wrap = 0;
            return;
        end
        m_errp = 0; m_wrap = 0; e = 0;
        if (v) begin
            if (m_mode == HUNTING) begin
                if (c < 5) begin
                    m_exp = nxt(c, d); m_run = 0; m_mode = SEEDED;
                end
            end else if (m_mode == SEEDED) begin
                if (c == m_exp) begin
                    m_run++; m_exp = nxt(c, d);
                    if (m_run == 2) begin m_mode = TRACKING; m_bad = 0; end
                end else if (c < 5) begin
                    m_exp = nxt(c, d); m_run = 0;
                end else m_mode = HUNTING;
            end else begin
                if (c == m_exp) begin
                    m_bad = 0; m_exp = nxt(c, d);
                    m_wrap = (c == (d ? 0 : 4));
                end else begin
                    e = 1; m_errp = 1; m_bad++;
                    m_exp = nxt(m_exp, d);
                    if (m_bad == 2) m_mode = HUNTING;
                end
            end
        end
        if (cl) m_err = e ? 1 : 0;
        else if (e && m_err < 255) m_err++;
    endtask

    task automatic step(input bit v, input int c, input bit d,
                        input bit cl, input bit r);
        in_valid = v; count_in = 3'(c); dir = d;
        clr_err = cl; reset = r;
        @(posedge clk);
        model(v, c, d, cl, r);
        #1;
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0, 0);
        total++;
        if ({lock, err_pulse, wrap_pulse, err_count, expected} !== 14'd0) begin
            bad++;
            $display("FAIL reset: got lock=%b ep=%b wp=%b err=%0d exp=%0d want all 0",
                     lock, err_pulse, wrap_pulse, err_count, expected);
        end
    endtask

    task automatic test_lock_up;
        int seq [7] = '{0, 1, 2, 3, 4, 0, 1};
        bit el  [7] = '{0, 0, 1, 1, 1, 1, 1};
        bit ew  [7] = '{0, 0, 0, 0, 1, 0, 0};
        int ee  [7] = '{1, 2, 3, 4, 0, 1, 2};
        for (int i = 0; i < 7; i++) begin
            step(1, seq[i], 0, 0, 1);
            total++;
            if (lock !== el[i] || wrap_pulse !== ew[i] || err_pulse !== 1'b0
                || expected !== 3'(ee[i])) begin
                bad++;
                $display("FAIL lock_up[%0d]: got lock=%b wp=%b ep=%b exp=%0d want %b %b 0 %0d",
                         i, lock, wrap_pulse, err_pulse, expected, el[i], ew[i], ee[i]);
            end
        end
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL lock_up_err: got %0d want 0", err_count);
        end
    endtask

    task automatic test_single_err;
        step(1, 2, 0, 0, 1); step(1, 3, 0, 0, 1); step(1, 4, 0, 0, 1);
        step(1, 2, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || lock !== 1'b1
            || expected !== 3'd1) begin
            bad++;
            $display("FAIL single_err: got ep=%b err=%0d lock=%b exp=%0d want 1 1 1 1",
                     err_pulse, err_count, lock, expected);
        end
        step(1, 1, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b0 || lock !== 1'b1 || expected !== 3'd2) begin
            bad++;
            $display("FAIL single_err_recover: got ep=%b lock=%b exp=%0d want 0 1 2",
                     err_pulse, lock, expected);
        end
    endtask

    task automatic test_unlock;
        step(1, 2, 0, 0, 1); step(1, 3, 0, 0, 1); step(1, 4, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || lock !== 1'b1) begin
            bad++;
            $display("FAIL unlock_first: got ep=%b err=%0d lock=%b want 1 2 1",
                     err_pulse, err_count, lock);
        end
        step(1, 3, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd3 || lock !== 1'b0) begin
            bad++;
            $display("FAIL unlock_second: got ep=%b err=%0d lock=%b want 1 3 0",
                     err_pulse, err_count, lock);
        end
        step(1, 4, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b0 || lock !== 1'b0 || expected !== 3'd0
            || err_count !== 8'd3) begin
            bad++;
            $display("FAIL unlock_reseed: got ep=%b lock=%b exp=%0d err=%0d want 0 0 0 3",
                     err_pulse, lock, expected, err_count);
        end
    endtask

    task automatic test_out_of_range;
        step(1, 0, 0, 0, 1); step(1, 1, 0, 0, 1);
        step(1, 7, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd4 || lock !== 1'b1
            || expected !== 3'd3) begin
            bad++;
            $display("FAIL oor_locked: got ep=%b err=%0d lock=%b exp=%0d want 1 4 1 3",
                     err_pulse, err_count, lock, expected);
        end
        step(1, 3, 0, 0, 1); step(1, 7, 0, 0, 1); step(1, 7, 0, 0, 1);
        step(1, 7, 0, 0, 1);
        total++;
        if (err_pulse !== 1'b0 || err_count !== 8'd6 || lock !== 1'b0) begin
            bad++;
            $display("FAIL oor_hunt: got ep=%b err=%0d lock=%b want 0 6 0",
                     err_pulse, err_count, lock);
        end
        step(1, 2, 0, 0, 1);
        total++;
        if (expected !== 3'd3 || lock !== 1'b0) begin
            bad++;
            $display("FAIL oor_seed: got exp=%0d lock=%b want 3 0", expected, lock);
        end
    endtask

    task automatic test_down_clr;
        int seq [6] = '{4, 3, 2, 1, 0, 4};
        bit el  [6] = '{0, 0, 1, 1, 1, 1};
        bit ew  [6] = '{0, 0, 0, 0, 1, 0};
        int ee  [6] = '{3, 2, 1, 0, 4, 3};
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i], 1, 0, 1);
            total++;
            if (lock !== el[i] || wrap_pulse !== ew[i] || expected !== 3'(ee[i])) begin
                bad++;
                $display("FAIL down[%0d]: got lock=%b wp=%b exp=%0d want %b %b %0d",
                         i, lock, wrap_pulse, expected, el[i], ew[i], ee[i]);
            end
        end
        step(1, 0, 1, 1, 1);
        total++;
        if (err_count !== 8'd1 || err_pulse !== 1'b1 || expected !== 3'd2) begin
            bad++;
            $display("FAIL clr_with_err: got err=%0d ep=%b exp=%0d want 1 1 2",
                     err_count, err_pulse, expected);
        end
        step(1, 2, 1, 1, 1);
        total++;
        if (err_count !== 8'd0 || err_pulse !== 1'b0 || lock !== 1'b1) begin
            bad++;
            $display("FAIL clr_plain: got err=%0d ep=%b lock=%b want 0 0 1",
                     err_count, err_pulse, lock);
        end
    endtask

    task automatic test_gaps_reset;
        bit vs [6] = '{1, 0, 1, 0, 0, 1};
        int cs [6] = '{0, 3, 1, 4, 4, 2};
        bit el [6] = '{0, 0, 0, 0, 0, 1};
        int ee [6] = '{1, 1, 2, 2, 2, 3};
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(vs[i], cs[i], 0, 0, 1);
            total++;
            if (lock !== el[i] || expected !== 3'(ee[i])
                || err_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
                bad++;
                $display("FAIL gaps[%0d]: got lock=%b exp=%0d ep=%b wp=%b want %b %0d 0 0",
                         i, lock, expected, err_pulse, wrap_pulse, el[i], ee[i]);
            end
        end
        step(1, 0, 0, 0, 1); step(1, 4, 0, 0, 1); step(1, 3, 0, 0, 1);
        step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 1);
        total++;
        if (lock !== 1'b1 || err_count !== 8'd3) begin
            bad++;
            $display("FAIL pre_reset: got lock=%b err=%0d want 1 3", lock, err_count);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (lock !== 1'b0 || err_count !== 8'd0 || expected !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got lock=%b err=%0d exp=%0d want 0 0 0",
                     lock, err_count, expected);
        end
    endtask

    task automatic test_saturate;
        int e;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1); step(1, 1, 0, 0, 1); step(1, 2, 0, 0, 1);
        e = 3;
        for (int i = 0; i < 300; i++) begin
            step(1, 6, 0, 0, 1);
            e = (e + 1) % 5;
            step(1, e, 0, 0, 1);
            e = (e + 1) % 5;
        end
        total++;
        if (err_count !== 8'd255 || lock !== 1'b1) begin
            bad++;
            $display("FAIL saturate: got err=%0d lock=%b want 255 1", err_count, lock);
        end
    endtask

    task automatic test_random;
        int g = 0;
        bit d = 0;
        int c, r;
        bit v, cl, rs;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 99) < 80);
            cl = ($urandom_range(0, 99) < 3);
            rs = !($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 2) d = ~d;
            r = $urandom_range(0, 99);
            c = (r < 8) ? $urandom_range(0, 7) : g;
            step(v, c, d, cl, rs);
            if (v) g = nxt(g, d);
            total++;
            if (lock !== (m_mode == TRACKING) || err_pulse !== m_errp
                || wrap_pulse !== m_wrap || err_count !== 8'(m_err)
                || expected !== 3'(m_exp)) begin
                bad++;
                $display("FAIL random[%0d]: got lock=%b ep=%b wp=%b err=%0d exp=%0d want %b %b %b %0d %0d",
                         i, lock, err_pulse, wrap_pulse, err_count, expected,
                         (m_mode == TRACKING), m_errp, m_wrap, m_err, m_exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; count_in = '0;
        dir = 1'b0; clr_err = 1'b0;
        test_reset;
        test_lock_up;
        test_single_err;
        test_unlock;
        test_out_of_range;
        test_down_clr;
        test_gaps_reset;
        test_saturate;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modn_seq_checker.md
Name: modn_seq_checker

Overview:
Receive-side monitor for the mod-N counter stream produced by the team's mod5 counter family. Samples a counter value each valid cycle, locks onto the legal wrap-around sequence (up or down), and predicts the next value with a flywheel. Flags and counts sequence errors, and pulses on terminal-count wrap. Sits downstream of any mod-N counter output (Q bus) for self-check and loss-of-sync detection.

Parameters:
MOD, 5, counter modulus; must be >= 2
W, 3, width of count_in and expected; must be >= clog2(MOD)
ERR_W, 8, width of the saturating error counter
LOCK_CNT, 2, consecutive matching samples after the seed needed to lock; must be >= 1
UNLOCK_ERRS, 2, consecutive errors while locked that force loss of lock; must be >= 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  count_in/dir are sampled only when high
count_in  input  W  observed counter value
dir  input  1  0 = count up expected, 1 = count down expected
clr_err  input  1  synchronous clear of err_count
lock  output  1  high while in LOCKED
err_pulse  output  1  one-cycle pulse per error detected while locked
wrap_pulse  output  1  one-cycle pulse on matched terminal value while locked
err_count  output  ERR_W  saturating count of errors
expected  output  W  value predicted for the next valid sample

Behaviour:
- Reset: when reset==0 at a posedge, state=HUNT; lock, err_pulse, wrap_pulse, err_count and expected all 0; the run counter and the bad-run counter cleared. Reset applies from any state and mid-stream.
- succ(x,dir): up gives (x==MOD-1) ? 0 : x+1; down gives (x==0) ? MOD-1 : x-1. dir is taken from the same valid sample.
- A sample is in-range if count_in < MOD.
- in_valid=0: all state, counters and expected hold; err_pulse and wrap_pulse are 0.
- All outputs are registered. Pulses are high for exactly the one cycle after the edge that sampled the causing value.
- HUNT:
  - in-range sample: seed it, set expected=succ(sample), run=0, go to SYNC.
  - out-of-range sample: stay in HUNT, no error counted.
- SYNC:
  - sample==expected: run++, expected=succ(sample). If run reaches LOCK_CNT, go to LOCKED with bad_run=0.
  - mismatch, in-range: re-seed from the sample (run=0, stay in SYNC).
  - mismatch, out-of-range: go to HUNT.
  - No errors are counted in SYNC.
- LOCKED:
  - match: bad_run=0, expected=succ(sample). wrap_pulse=1 if the sample is the terminal value (MOD-1 when up, 0 when down).
  - mismatch or out-of-range: err_pulse=1, err_count+1 (saturating at all-ones), bad_run++. expected=succ(expected), i.e. the flywheel advances and ignores the bad sample.
  - If bad_run reaches UNLOCK_ERRS: go to HUNT, lock=0.
- clr_err: err_count=0. If an error occurs in the same cycle, err_count=1 and err_pulse is still asserted.
- No arithmetic overflow on W: successor math is compare-and-wrap only, never modular on 2^W.

Decomposition:
- Shared package modn_pkg:
  - state encoding constants ST_HUNT=2'd0, ST_SYNC=2'd1, ST_LOCKED=2'd2
  - default MOD/W constants
- Sub-module modn_next: combinational successor, with params MOD and W, inputs x and dir, output next. It is reusable by future mod-N up/down counters.

Test Plan:
(All scenarios use MOD=5, LOCK_CNT=2, UNLOCK_ERRS=2.)
1. Reset low 1 cycle, then up stream 0,1,2,3,4,0,1 with in_valid=1 every cycle -> lock rises the cycle after sample 2 is sampled; wrap_pulse exactly 1 cycle after sample 4; err_count=0; expected=2 at the end.
2. Locked up with expected 0: feed 2 then 1 -> err_pulse once, err_count=1, lock stays 1, expected=2 after the 1.
3. Locked up with expected 0: feed 3,3 -> two err_pulses, err_count=2, lock=0 after the second; next sample 4 re-seeds via HUNT into SYNC.
4. Out-of-range 7 while locked -> error counted (err_count+1). 7 while in HUNT -> no count, stays in HUNT.
5. dir=1, stream 4,3,2,1,0,4 -> lock after 2; wrap_pulse 1 cycle after 0; then clr_err together with an injected error -> err_count=1.
6. Stream 0,1,2 with in_valid=0 gaps between samples -> same lock timing relative to valid samples. Then, locked with err_count=3, hold reset low 1 cycle -> lock=0, err_count=0, expected=0 next cycle.
